// File: rtl/pixel_burst_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_burst_engine: SRAM burst reader/writer with greyscale pixel buffer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_burst_engine #(
  parameter int ADDR_W        = 16,
  parameter int PIX_W         = 8,
  parameter int CH_W          = 8,
  parameter int MAX_BURST     = 20,
  parameter int ACCESS_CYCLES = 4,
  parameter int CNT_W         = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic                       grey_en,
  input  logic [ADDR_W-1:0]          rd_base,
  input  logic [ADDR_W-1:0]          wr_base,
  input  logic [CNT_W-1:0]           rd_count,
  input  logic [CNT_W-1:0]           wr_count,
  input  logic [MAX_BURST*PIX_W-1:0] data_in,
  output logic [MAX_BURST*PIX_W-1:0] data_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_W-1:0]          address,
  output logic [3*CH_W-1:0]          w_data,
  input  logic [3*CH_W-1:0]          r_data,
  output logic                       read_enable,
  output logic                       write_enable
);

  localparam int SUM_W = CH_W + 2;
  localparam int CYC_W = $clog2(ACCESS_CYCLES);

  localparam logic [1:0]       c_mode_rd   = 2'b00;
  localparam logic [1:0]       c_mode_wr   = 2'b01;
  localparam logic [1:0]       c_mode_rw   = 2'b10;
  localparam logic [1:0]       c_mode_bad  = 2'b11;
  localparam logic [CYC_W-1:0] c_cyc_last  = CYC_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_max_burst = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic                grey_q, grey_d;
  logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
  logic [ADDR_W-1:0]   wr_base_q, wr_base_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic                err_flag_q, err_flag_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [3*CH_W-1:0]   w_data_q, w_data_d;
  logic                re_q, re_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PIX_W-1:0]    buf_q [MAX_BURST];
  logic [PIX_W-1:0]    buf_d [MAX_BURST];

  logic [PIX_W-1:0]    din_pix [MAX_BURST];
  logic [CNT_W-1:0]    idx_next;
  logic                illegal;

  generate
    for (genvar i = 0; i < MAX_BURST; i++) begin : g_pix_map
      assign din_pix[i]                     = data_in[i*PIX_W +: PIX_W];
      assign data_out[i*PIX_W +: PIX_W]     = buf_q[i];
    end
  endgenerate

  // Greyscale approximates (R+G+B)/3 with a shift-add series on the channel sum.
  logic [SUM_W-1:0]       rgb_sum;
  logic [SUM_W-1:0]       grey_full;
  logic [PIX_W+SUM_W-1:0] grey_wide;
  logic [PIX_W+CH_W-1:0]  blue_wide;
  logic [PIX_W-1:0]       rd_pix;

  assign rgb_sum   = SUM_W'(r_data[3*CH_W-1 -: CH_W]) + SUM_W'(r_data[2*CH_W-1 -: CH_W])
                   + SUM_W'(r_data[CH_W-1:0]);
  assign grey_full = (rgb_sum >> 2) + (rgb_sum >> 4) + (rgb_sum >> 6) + (rgb_sum >> 8);
  assign grey_wide = {{PIX_W{1'b0}}, grey_full};
  assign blue_wide = {{PIX_W{1'b0}}, r_data[CH_W-1:0]};
  assign rd_pix    = grey_q ? grey_wide[PIX_W-1:0] : blue_wide[PIX_W-1:0];

  function automatic logic [3*CH_W-1:0] pix_word(input logic [PIX_W-1:0] p);
    logic [CH_W+PIX_W-1:0] w;
    w = {{CH_W{1'b0}}, p};
    return {3{w[CH_W-1:0]}};
  endfunction

  assign illegal = (mode == c_mode_bad)
                || ((mode != c_mode_wr) && (rd_count > c_max_burst))
                || ((mode != c_mode_rd) && (wr_count > c_max_burst));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    grey_d     = grey_q;
    rd_base_d  = rd_base_q;
    wr_base_d  = wr_base_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    err_flag_d = err_flag_q;
    idx_d      = idx_q;
    cyc_d      = cyc_q;
    address_d  = address_q;
    w_data_d   = w_data_q;
    re_d       = re_q;
    we_d       = we_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    buf_d      = buf_q;
    idx_next   = idx_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          grey_d     = grey_en;
          rd_base_d  = rd_base;
          wr_base_d  = wr_base;
          rd_cnt_d   = rd_count;
          wr_cnt_d   = wr_count;
          err_flag_d = illegal;
          busy_d     = 1'b1;
          idx_d      = '0;
          cyc_d      = '0;
          // Illegal or empty phases enter the state without an access and leave next cycle.
          if (mode == c_mode_wr) begin
            state_d = S_WRITE;
            if (!illegal && (wr_count != '0)) begin
              we_d      = 1'b1;
              address_d = wr_base;
              w_data_d  = pix_word(din_pix[0]);
            end
          end else begin
            state_d = S_READ;
            if (!illegal && (rd_count != '0)) begin
              re_d      = 1'b1;
              address_d = rd_base;
            end
          end
        end
      end

      S_READ: begin
        if (re_q && (cyc_q != c_cyc_last)) begin
          cyc_d = cyc_q + CYC_W'(1);
        end else begin
          if (re_q) begin
            buf_d[idx_q] = rd_pix;
          end
          if (re_q && (idx_next != rd_cnt_q)) begin
            idx_d     = idx_next;
            cyc_d     = '0;
            address_d = rd_base_q + ADDR_W'(idx_next);
          end else begin
            re_d  = 1'b0;
            idx_d = '0;
            cyc_d = '0;
            if ((mode_q == c_mode_rw) && !err_flag_q) begin
              state_d = S_WRITE;
              if (wr_cnt_q != '0) begin
                we_d      = 1'b1;
                address_d = wr_base_q;
                w_data_d  = pix_word(din_pix[0]);
              end
            end else begin
              state_d = S_FINISH;
            end
          end
        end
      end

      S_WRITE: begin
        if (we_q && (cyc_q != c_cyc_last)) begin
          cyc_d = cyc_q + CYC_W'(1);
        end else if (we_q && (idx_next != wr_cnt_q)) begin
          idx_d     = idx_next;
          cyc_d     = '0;
          address_d = wr_base_q + ADDR_W'(idx_next);
          w_data_d  = pix_word(din_pix[idx_next]);
        end else begin
          we_d    = 1'b0;
          idx_d   = '0;
          cyc_d   = '0;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        err_d      = err_flag_q;
        err_flag_d = 1'b0;
        busy_d     = 1'b0;
        re_d       = 1'b0;
        we_d       = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= c_mode_rd;
      grey_q     <= 1'b0;
      rd_base_q  <= '0;
      wr_base_q  <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      err_flag_q <= 1'b0;
      idx_q      <= '0;
      cyc_q      <= '0;
      address_q  <= '0;
      w_data_q   <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_BURST; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      grey_q     <= grey_d;
      rd_base_q  <= rd_base_d;
      wr_base_q  <= wr_base_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_flag_q <= err_flag_d;
      idx_q      <= idx_d;
      cyc_q      <= cyc_d;
      address_q  <= address_d;
      w_data_q   <= w_data_d;
      re_q       <= re_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      buf_q      <= buf_d;
    end
  end

  assign address      = address_q;
  assign w_data       = w_data_q;
  assign read_enable  = re_q;
  assign write_enable = we_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_burst_engine.sv
`default_nettype none
// Directed bench for pixel_burst_engine: timed bursts against a small SRAM lookup table.
module tb_pixel_burst_engine;

  localparam int LOG_N = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic         grey_en;
  logic [15:0]  rd_base, wr_base;
  logic [4:0]   rd_count, wr_count;
  logic [159:0] data_in;
  logic [159:0] data_out;
  logic         busy, done, err;
  logic [15:0]  address;
  logic [23:0]  w_data;
  logic [23:0]  r_data;
  logic         read_enable, write_enable;

  int total = 0;
  int bad   = 0;

  logic [15:0] log_addr [LOG_N];
  logic        log_re   [LOG_N];
  logic        log_we   [LOG_N];
  logic [23:0] log_wd   [LOG_N];
  int          done_at, done_pulses, n_re, n_we, n_err;
  logic        done_err;
  logic        both_hi = 1'b0;

  always #5 clk = ~clk;

  pixel_burst_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .grey_en(grey_en),
    .rd_base(rd_base), .wr_base(wr_base), .rd_count(rd_count), .wr_count(wr_count),
    .data_in(data_in), .data_out(data_out), .busy(busy), .done(done), .err(err),
    .address(address), .w_data(w_data), .r_data(r_data),
    .read_enable(read_enable), .write_enable(write_enable)
  );

  function automatic logic [23:0] sram(input logic [15:0] a);
    case (a)
      16'h0100: return 24'hFFFFFF;
      16'h0101: return 24'h306090;
      16'h0102: return 24'h000000;
      16'h0200: return 24'h12345A;
      16'h0300: return 24'h0000AB;
      16'h0301: return 24'h0000CD;
      default:  return 24'h777777;
    endcase
  endfunction

  assign r_data = sram(address);

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; c counts cycles after the accepting edge.
  task automatic run(input logic [1:0] m, input logic g, input logic [15:0] rb,
                     input logic [15:0] wb, input logic [4:0] rc, input logic [4:0] wc,
                     input int pulse_at);
    mode = m; grey_en = g; rd_base = rb; wr_base = wb; rd_count = rc; wr_count = wc;
    start = 1'b1;
    done_at = -1; done_err = 1'b0; done_pulses = 0; n_re = 0; n_we = 0; n_err = 0;
    for (int c = 0; c < LOG_N; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == 1) begin
        rd_base = ~rb; wr_base = ~wb; rd_count = rc + 5'd1; wr_count = wc + 5'd1;
      end
      log_addr[c] = address; log_re[c] = read_enable;
      log_we[c]   = write_enable; log_wd[c] = w_data;
      if (read_enable) n_re++;
      if (write_enable) n_we++;
      if (err) n_err++;
      if (read_enable && write_enable) both_hi = 1'b1;
      if (done) begin
        if (done_at < 0) begin
          done_at  = c;
          done_err = err;
        end
        done_pulses++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; grey_en = 1'b0;
    rd_base = '0; wr_base = '0; rd_count = '0; wr_count = '0; data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr", address, 0);
    check("rst_wdata", w_data, 0);
    check("rst_re", read_enable, 0);
    check("rst_we", write_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_buf", data_out, 0);

    // Greyscale read of three pixels.
    run(2'b00, 1'b1, 16'h0100, 16'h0000, 5'd3, 5'd0, -1);
    check("g_done_at", done_at, 13);
    check("g_pulses", done_pulses, 1);
    check("g_err", done_err, 0);
    check("g_nre", n_re, 12);
    check("g_nwe", n_we, 0);
    check("g_a0s", log_addr[0], 16'h0100);
    check("g_a0e", log_addr[3], 16'h0100);
    check("g_a1s", log_addr[4], 16'h0101);
    check("g_a1e", log_addr[7], 16'h0101);
    check("g_a2s", log_addr[8], 16'h0102);
    check("g_a2e", log_addr[11], 16'h0102);
    check("g_re_end", log_re[12], 0);
    check("g_buf0", data_out[7:0], 8'hFB);
    check("g_buf1", data_out[15:8], 8'h5F);
    check("g_buf2", data_out[23:16], 8'h00);

    // Raw read of one pixel; buffer[1] keeps its earlier value.
    run(2'b00, 1'b0, 16'h0200, 16'h0000, 5'd1, 5'd0, -1);
    check("raw_done_at", done_at, 5);
    check("raw_buf0", data_out[7:0], 8'h5A);
    check("raw_buf1", data_out[15:8], 8'h5F);

    // Read-then-write with an ignored start pulse mid-burst.
    data_in[7:0] = 8'h11; data_in[15:8] = 8'h22;
    run(2'b10, 1'b0, 16'h0300, 16'h2000, 5'd2, 5'd2, 5);
    check("rw_done_at", done_at, 17);
    check("rw_pulses", done_pulses, 1);
    check("rw_nre", n_re, 8);
    check("rw_nwe", n_we, 8);
    check("rw_re7", log_re[7], 1);
    check("rw_we7", log_we[7], 0);
    check("rw_we8", log_we[8], 1);
    check("rw_a8", log_addr[8], 16'h2000);
    check("rw_wd8", log_wd[8], 24'h111111);
    check("rw_a12", log_addr[12], 16'h2001);
    check("rw_wd15", log_wd[15], 24'h222222);
    check("rw_we16", log_we[16], 0);
    check("rw_buf0", data_out[7:0], 8'hAB);
    check("rw_buf1", data_out[15:8], 8'hCD);

    // Write-only burst wrapping the address space.
    run(2'b01, 1'b0, 16'h0000, 16'hFFFF, 5'd0, 5'd2, -1);
    check("wrap_done_at", done_at, 9);
    check("wrap_a0", log_addr[0], 16'hFFFF);
    check("wrap_a4", log_addr[4], 16'h0000);
    check("wrap_wd0", log_wd[0], 24'h111111);
    check("wrap_nwe", n_we, 8);
    check("wrap_nre", n_re, 0);

    // Oversized count and reserved mode.
    run(2'b00, 1'b1, 16'h0100, 16'h0000, 5'd21, 5'd0, -1);
    check("big_done_at", done_at, 2);
    check("big_err", done_err, 1);
    check("big_nerr", n_err, 1);
    check("big_access", n_re + n_we, 0);
    run(2'b11, 1'b1, 16'h0100, 16'h0000, 5'd1, 5'd1, -1);
    check("m11_done_at", done_at, 2);
    check("m11_err", done_err, 1);
    check("m11_access", n_re + n_we, 0);

    // Reset during the second read access.
    mode = 2'b00; grey_en = 1'b1; rd_base = 16'h0100; rd_count = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_re", read_enable, 1);
    check("mid_addr", address, 16'h0101);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_re", read_enable, 0);
    check("mrst_busy", busy, 0);
    check("mrst_addr", address, 0);
    check("mrst_buf", data_out, 0);
    run(2'b00, 1'b0, 16'h0200, 16'h0000, 5'd1, 5'd0, -1);
    check("post_done_at", done_at, 5);
    check("post_buf0", data_out[7:0], 8'h5A);

    check("never_both", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
